// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider feeding the HI/LO pair.
// Quotient is written to LO and remainder to HI. busy stalls EX while iterating,
// and done pulses for one cycle when hilo has just been updated. Both signed
// (DIV) and unsigned (DIVU) division are supported, and a flush can cancel the
// operation in flight.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Two's complement negation when the enable is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    cond_neg = en ? (~v + ONE) : v;
  endfunction

  // Operand magnitude: only signed operands with the sign bit set are negated.
  // The most negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    magnitude = cond_neg(v, is_signed & v[WIDTH-1]);
  endfunction

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] b_mag;
  logic             q_sign;
  logic             r_sign;
  logic [CW-1:0]    count;

  logic             accept;
  logic             b_zero;
  logic             last_step;
  logic             busy_next;
  logic             done_next;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign accept    = start & ~cancel & ((state == IDLE) | (state == FIN));
  assign b_zero    = (b == {WIDTH{1'b0}});
  assign last_step = (count == LAST_STEP);

  // One restoring step: shift {rem, quo} left and keep the trial subtraction if it fits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= {1'b0, b_mag});
    rem_step = shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_step    = shifted[WIDTH-1:0] - b_mag;
      quo_step[0] = 1'b1;
    end else begin
      rem_step    = shifted[WIDTH-1:0];
      quo_step[0] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; cancel overrides both new starts and completion.
  always_comb begin
    next_state = state;
    if (cancel) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            next_state = b_zero ? FIN : CALC;
          end else begin
            next_state = IDLE;
          end
        end
        CALC: begin
          if (last_step) begin
            next_state = FIN;
          end else begin
            next_state = CALC;
          end
        end
        FIN: begin
          if (accept) begin
            next_state = b_zero ? FIN : CALC;
          end else begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so busy/done can be registered.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    case (next_state)
      CALC:    busy_next = 1'b1;
      FIN:     done_next = 1'b1;
      default: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Datapath: operand capture, iteration and result write-back (only on entry to FIN).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= {WIDTH{1'b0}};
      quo    <= {WIDTH{1'b0}};
      b_mag  <= {WIDTH{1'b0}};
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      count  <= {CW{1'b0}};
      hilo   <= {(2*WIDTH){1'b0}};
    end else if (!cancel) begin
      if (accept) begin
        count <= {CW{1'b0}};
        if (b_zero) begin
          hilo <= {a, {WIDTH{1'b1}}};
        end else begin
          rem    <= {WIDTH{1'b0}};
          quo    <= magnitude(a, signed_div);
          b_mag  <= magnitude(b, signed_div);
          q_sign <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
          r_sign <= a[WIDTH-1] & signed_div;
        end
      end else if (state == CALC) begin
        rem   <= rem_step;
        quo   <= quo_step;
        count <= count + {{(CW-1){1'b0}}, 1'b1};
        if (last_step) begin
          hilo <= {cond_neg(rem_step, r_sign), cond_neg(quo_step, q_sign)};
        end
      end else begin
        count <= count;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit (WIDTH = 32).
module tb_hilo_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [63:0] hilo;

  int n_checks;
  int n_fail;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .hilo       (hilo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one divide from the current negedge and stop at the negedge where done is seen.
  // poke > 0 drives a competing start (50/3) in that cycle after acceptance.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [63:0] exp_hilo,
                        input int exp_lat, input int poke);
    int lat;
    int busy_cnt;
    int hilo_moves;
    logic [63:0] prev;
    prev       = hilo;
    busy_cnt   = 0;
    hilo_moves = 0;
    start      = 1'b1;
    signed_div = sgn;
    a          = aa;
    b          = bb;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (hilo !== prev) hilo_moves++;
      if (lat == poke) begin
        start = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check_val({tag, " hilo stable during calc"}, 64'(hilo_moves), 64'd0);
    check_val({tag, " busy low with done"}, {63'd0, busy}, 64'd0);
    check_val({tag, " hilo"}, hilo, exp_hilo);
  endtask

  // One cycle past completion: done must drop and the result must be held.
  task automatic check_idle_after(input string tag, input logic [63:0] exp_hilo);
    @(negedge clk);
    check_val({tag, " done pulse one cycle"}, {63'd0, done}, 64'd0);
    check_val({tag, " busy idle"}, {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check_val({tag, " hilo held"}, hilo, exp_hilo);
  endtask

  initial begin
    int done_cnt;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    cancel     = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset busy", {63'd0, busy}, 64'd0);
    check_val("reset done", {63'd0, done}, 64'd0);
    check_val("reset hilo", hilo, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    check_idle_after("divu 100/7", {32'd2, 32'd14});

    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    check_idle_after("div -7/2", {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0);
    check_idle_after("div 7/-2", {32'd1, 32'hFFFF_FFFD});

    do_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33, 0);
    check_idle_after("div -100/-7", {32'hFFFF_FFFE, 32'd14});

    do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0);
    check_idle_after("div min/-1", {32'd0, 32'h8000_0000});

    do_div("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33, 0);
    check_idle_after("divu min/max", {32'h8000_0000, 32'd0});

    do_div("div by zero", 1'b1, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1, 0);
    check_idle_after("div by zero", {32'h0000_1234, 32'hFFFF_FFFF});

    // Cancel at T+10 of DIVU 100/7: no done, hilo keeps the divide-by-zero result.
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("cancel busy before", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_val("cancel busy after", {63'd0, busy}, 64'd0);
    check_val("cancel done after", {63'd0, done}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check_val("cancel no completion", 64'(done_cnt), 64'd0);
    check_val("cancel hilo kept", hilo, {32'h0000_1234, 32'hFFFF_FFFF});

    // Cancel together with start in IDLE: nothing starts.
    start = 1'b1; cancel = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check_val("cancel+start ignored", 64'(done_cnt), 64'd0);
    check_val("cancel+start hilo kept", hilo, {32'h0000_1234, 32'hFFFF_FFFF});

    // Start during CALC is ignored; then a start in the FIN cycle runs back-to-back.
    do_div("divu poked", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 5);
    do_div("divu 9/4 b2b", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 0);
    check_idle_after("divu 9/4 b2b", {32'd1, 32'd2});

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid reset busy", {63'd0, busy}, 64'd0);
    check_val("mid reset done", {63'd0, done}, 64'd0);
    check_val("mid reset hilo", hilo, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check_val("after reset idle", 64'(done_cnt), 64'd0);

    do_div("divu 9/4 post reset", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 0);
    check_idle_after("divu 9/4 post reset", {32'd1, 32'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Iterative radix-2 divider that produces the 64-bit HI/LO value read by the execute-stage ALU (MFHI/MFLO paths).
- Writer side of the hilo interface for DIV/DIVU: quotient goes to LO, remainder to HI.
- Sits beside the ALU in EX. It holds the pipeline via busy and flags completion via a one-cycle done pulse.
- Supports flush cancellation from exception/branch recovery.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH. The iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request a divide. Sampled only when the block can accept.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- a  input  WIDTH  dividend. Sampled with start.
- b  input  WIDTH  divisor. Sampled with start.
- cancel  input  1  flush. Aborts any operation in flight.
- busy  output  1  operation in progress. EX must stall.
- done  output  1  one-cycle pulse. hilo is valid and newly updated.
- hilo  output  2*WIDTH  {remainder, quotient}, i.e. HI = remainder, LO = quotient. Held until the next completion.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, hilo=0, counter=0, internal operand/partial-remainder registers cleared.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - FIN: one-cycle completion, done=1.
- Accept condition: start=1 in IDLE or FIN, and cancel=0. A start during CALC is ignored; no queuing.
- Accept with b != 0, cycle T:
  - Latch |a|, |b| (magnitudes when signed_div, raw values otherwise), the quotient sign (a[MSB]^b[MSB]) & signed_div, and the remainder sign a[MSB] & signed_div.
  - Clear the counter. Next state is CALC.
- CALC, cycles T+1 .. T+WIDTH:
  - busy=1. One restoring step per cycle: shift {rem, quo} left 1 and trial-subtract |b|.
  - If the trial result is non-negative, keep it and set the quotient LSB to 1.
  - The counter increments each cycle. On the last step (counter==WIDTH-1), apply the sign fix-ups, write hilo, and go to FIN.
- Sign fix-ups: negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1. Results are modulo 2^WIDTH.
  - Signed min / -1 (0x80000000 / 0xFFFFFFFF) gives LO=0x80000000, HI=0. No trap.
- FIN, cycle T+WIDTH+1: done=1, busy=0, hilo valid. Next state is IDLE, or CALC if a new start is accepted (back-to-back).
- Latency: done rises WIDTH+1 cycles after the start cycle (33 for WIDTH=32).
- Divide by zero (b==0 at accept):
  - Skip CALC and go directly to FIN at T+1.
  - hilo = {a, all-ones} for both DIV and DIVU. busy is never asserted.
- cancel:
  - In any state, forces IDLE at the next edge. busy=0 and done=0 from the next cycle.
  - hilo is not updated; it keeps its previous value.
  - cancel has priority over start and over completion in the same cycle.
  - cancel in the FIN cycle does not suppress that cycle's done, which is already registered.
- done is registered and high for exactly one cycle per completed operation.
- busy and done are never high together.
- hilo changes only on the edge entering FIN.
- Operand inputs are don't-care except in the accept cycle.

Test Plan:
- DIVU a=100, b=7, start at T → busy T+1..T+32, done at T+33, hilo={32'd2, 32'd14}, then idle with hilo held.
- DIV a=-7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also DIV a=7, b=-2 → LO=0xFFFFFFFD, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, done at T+33. DIVU same operands → LO=0, HI=0x80000000.
- Divide by zero, a=0x1234, b=0 → done at T+1, busy never high, hilo={0x00001234, 0xFFFFFFFF}.
- Cancel at T+10 of DIVU 100/7 with prior hilo=X → busy low from T+11, no done, hilo remains X. Cancel together with start in IDLE → no operation starts.
- start during CALC with different operands → ignored, first result unchanged. start in the FIN cycle (DIVU 9/4) → second done exactly 33 cycles later with hilo={1, 2}. rst asserted mid-CALC → outputs immediately 0, state IDLE.
